// File: rtl/color_freq_pkg.sv
// Shared types for the colour-sensor sweep: FSM states, TCS3200 filter codes
// and the channel index that orders the sweep.
package color_freq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    STORE  = 2'd3
  } state_e;

  typedef logic [1:0] chan_idx_t;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // Sweep order is red, green, blue, clear; the {S2,S3} codes are not in that order.
  function automatic logic [1:0] filt_of(input chan_idx_t idx);
    logic [1:0] f;
    case (idx)
      2'd0:    f = FILT_RED;
      2'd1:    f = FILT_GREEN;
      2'd2:    f = FILT_BLUE;
      default: f = FILT_CLEAR;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/color_freq_sequencer_edge_gate_counter.sv
// Synchronises the asynchronous sensor square wave, detects rising edges and
// counts them into a saturating counter while enabled.
module edge_gate_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic             sync1_q, sync2_q, sync3_q;
  logic             edge_det;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign edge_det = sync2_q & ~sync3_q;
  // ovf flags an edge that arrived while the counter was already pinned at max.
  assign ovf      = en & edge_det & (cnt_q == {CNT_W{1'b1}});
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && edge_det && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sensor_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/color_freq_sequencer.sv
// Sweeps the colour sensor through red/green/blue/clear filters, gating an edge
// counter per filter after a settling delay and latching one result per channel.
module color_freq_sequencer
  import color_freq_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_freq,
  input  logic             start,
  input  logic             continuous,
  output logic [1:0]       filter_sel,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_red,
  output logic [CNT_W-1:0] cnt_green,
  output logic [CNT_W-1:0] cnt_blue,
  output logic [CNT_W-1:0] cnt_clear,
  output logic             sweep_done,
  output logic             overflow
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  chan_idx_t        idx_q, idx_d;
  logic [1:0]       filter_sel_q, filter_sel_d;
  logic [CNT_W-1:0] cnt_red_q, cnt_red_d, cnt_green_q, cnt_green_d;
  logic [CNT_W-1:0] cnt_blue_q, cnt_blue_d, cnt_clear_q, cnt_clear_d;
  logic             sweep_done_q, sweep_done_d;
  logic             overflow_q, overflow_d;
  logic             cnt_clr, cnt_en, cnt_ovf;
  logic [CNT_W-1:0] edge_cnt;

  edge_gate_counter #(.CNT_W(CNT_W)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .sensor_in (sensor_freq),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .cnt       (edge_cnt),
    .ovf       (cnt_ovf)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    cnt_red_d    = cnt_red_q;
    cnt_green_d  = cnt_green_q;
    cnt_blue_d   = cnt_blue_q;
    cnt_clear_d  = cnt_clear_q;
    sweep_done_d = 1'b0;
    overflow_d   = overflow_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || continuous) begin
          if (start) overflow_d = 1'b0;
          idx_d   = '0;
          timer_d = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          cnt_clr = 1'b1;
          state_d = GATE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GATE: begin
        cnt_en = 1'b1;
        if (cnt_ovf) overflow_d = 1'b1;
        if (timer_q == WINDOW_LAST) begin
          timer_d = '0;
          state_d = STORE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STORE: begin
        case (idx_q)
          2'd0:    cnt_red_d   = edge_cnt;
          2'd1:    cnt_green_d = edge_cnt;
          2'd2:    cnt_blue_d  = edge_cnt;
          default: cnt_clear_d = edge_cnt;
        endcase
        if (idx_q == 2'd3) begin
          sweep_done_d = 1'b1;
          idx_d        = '0;
          state_d      = continuous ? SETTLE : IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Decoding idx_d makes the filter change on the same edge that enters SETTLE.
    filter_sel_d = filt_of(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      filter_sel_q <= FILT_RED;
      cnt_red_q    <= '0;
      cnt_green_q  <= '0;
      cnt_blue_q   <= '0;
      cnt_clear_q  <= '0;
      sweep_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      filter_sel_q <= filter_sel_d;
      cnt_red_q    <= cnt_red_d;
      cnt_green_q  <= cnt_green_d;
      cnt_blue_q   <= cnt_blue_d;
      cnt_clear_q  <= cnt_clear_d;
      sweep_done_q <= sweep_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign filter_sel = filter_sel_q;
  assign busy       = (state_q != IDLE);
  assign cnt_red    = cnt_red_q;
  assign cnt_green  = cnt_green_q;
  assign cnt_blue   = cnt_blue_q;
  assign cnt_clear  = cnt_clear_q;
  assign sweep_done = sweep_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_color_freq_sequencer.sv
// Bench for color_freq_sequencer: table-driven sweeps with a scoreboard, plus
// saturation, continuous-mode and mid-sweep reset sequences.
module tb_color_freq_sequencer;

  localparam int W   = 100;
  localparam int S   = 10;
  localparam int LAT = 4 * (S + W + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sensor = 1'b0;
  logic        start = 1'b0, continuous = 1'b0;
  logic        start_s = 1'b0, continuous_s = 1'b0;

  logic [1:0]  filter_sel, filter_sel_s;
  logic        busy, sweep_done, overflow;
  logic        busy_s, sweep_done_s, overflow_s;
  logic [15:0] cnt_red, cnt_green, cnt_blue, cnt_clear;
  logic [3:0]  cnt_red_s, cnt_green_s, cnt_blue_s, cnt_clear_s;

  color_freq_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_freq(sensor), .start(start), .continuous(continuous),
    .filter_sel(filter_sel), .busy(busy), .cnt_red(cnt_red), .cnt_green(cnt_green),
    .cnt_blue(cnt_blue), .cnt_clear(cnt_clear), .sweep_done(sweep_done), .overflow(overflow)
  );

  color_freq_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .sensor_freq(sensor), .start(start_s), .continuous(continuous_s),
    .filter_sel(filter_sel_s), .busy(busy_s), .cnt_red(cnt_red_s), .cnt_green(cnt_green_s),
    .cnt_blue(cnt_blue_s), .cnt_clear(cnt_clear_s), .sweep_done(sweep_done_s), .overflow(overflow_s)
  );

  always #5 clk = ~clk;

  // Sensor period (in clk cycles) per channel red/green/blue/clear, chosen by dut's filter_sel.
  int per[4] = '{10, 10, 10, 10};

  function automatic int chan_of(input logic [1:0] f);
    case (f)
      2'b00:   return 0;
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    int ph;
    ph = 0;
    #2;
    forever begin
      #1;
      ph++;
      if (ph >= per[chan_of(filter_sel)] * 5) begin
        ph = 0;
        sensor = ~sensor;
      end
    end
  end

  typedef struct { int r; int g; int b; int c; } exp_t;
  typedef struct { int pr; int pg; int pb; int pc; int er; int eg; int eb; int ec; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard: every sweep_done of the 16-bit instance is checked against the queue.
  always @(negedge clk) begin
    if (sweep_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_sweep_done", 1, 0, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("cnt_red",   int'(cnt_red),   mon_e.r - 1, mon_e.r + 1);
        chk("cnt_green", int'(cnt_green), mon_e.g - 1, mon_e.g + 1);
        chk("cnt_blue",  int'(cnt_blue),  mon_e.b - 1, mon_e.b + 1);
        chk("cnt_clear", int'(cnt_clear), mon_e.c - 1, mon_e.c + 1);
        chk("overflow_clear_run", int'(overflow), 0, 0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1, 1);
  endtask

  // Waits for sweep_done, counting cycles from the negedge after the sweep began.
  task automatic wait_done(input int poke_at, input bit drop_on_blue,
                           output int lat, output logic [7:0] seq, output int nseq);
    logic [1:0] last;
    lat  = 0;
    last = filter_sel;
    seq  = {6'b0, filter_sel};
    nseq = 1;
    while (1) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (sweep_done) break;
      if (lat >= 3000) begin
        chk("sweep_timeout", lat, 0, 2999);
        break;
      end
      if (filter_sel != last) begin
        last = filter_sel;
        seq  = {seq[5:0], filter_sel};
        nseq++;
      end
      if (lat == poke_at) start = 1'b1;
      if (drop_on_blue && continuous && filter_sel == 2'b01) begin
        continuous = 1'b0;
        start      = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  vec_t       vecs[4];
  int         lat, nseq, cnt_busy;
  logic [7:0] seq;

  initial begin
    vecs[0] = '{10, 10, 10, 10, 10, 10, 10, 10};
    vecs[1] = '{5, 10, 20, 50, 20, 10, 5, 2};
    vecs[2] = '{50, 20, 10, 5, 2, 5, 10, 20};
    vecs[3] = '{25, 25, 25, 25, 4, 4, 4, 4};

    // Reset state and idle behaviour
    repeat (3) @(negedge clk);
    chk("rst_cnt_red", int'(cnt_red), 0, 0);
    chk("rst_cnt_clear", int'(cnt_clear), 0, 0);
    chk("rst_filter_sel", int'(filter_sel), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_overflow", int'(overflow), 0, 0);
    rst_n = 1'b1;
    cnt_busy = 0;
    repeat (600) begin
      @(negedge clk);
      if (busy || sweep_done) cnt_busy++;
    end
    chk("idle_no_activity", cnt_busy, 0, 0);
    chk("idle_cnt_green", int'(cnt_green), 0, 0);

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) begin
      per = '{vecs[i].pr, vecs[i].pg, vecs[i].pb, vecs[i].pc};
      sb.push_back('{vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ec});
      pulse_start();
      wait_done(-1, 1'b0, lat, seq, nseq);
      chk("sweep_latency", lat, LAT, LAT);
      chk("filter_seq", int'(seq), 'h36, 'h36);
      chk("filter_changes", nseq, 4, 4);
    end

    // Saturation on the 4-bit instance
    per = '{4, 4, 4, 4};
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    lat = 0;
    while (!sweep_done_s && lat < 3000) begin @(negedge clk); lat++; end
    chk("sat_latency", lat, LAT, LAT);
    chk("sat_red", int'(cnt_red_s), 15, 15);
    chk("sat_green", int'(cnt_green_s), 15, 15);
    chk("sat_blue", int'(cnt_blue_s), 15, 15);
    chk("sat_clear", int'(cnt_clear_s), 15, 15);
    chk("sat_overflow", int'(overflow_s), 1, 1);
    per = '{50, 50, 50, 50};
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    chk("ovf_cleared_by_start", int'(overflow_s), 0, 0);
    lat = 0;
    while (!sweep_done_s && lat < 3000) begin @(negedge clk); lat++; end
    chk("slow_latency", lat, LAT, LAT);
    chk("slow_overflow", int'(overflow_s), 0, 0);
    chk("slow_red", int'(cnt_red_s), 1, 3);

    // Continuous mode: three sweeps, start pokes ignored, drop during blue of the third
    per = '{10, 10, 10, 10};
    repeat (3) sb.push_back('{10, 10, 10, 10});
    @(negedge clk); continuous = 1'b1;
    @(negedge clk);
    chk("cont_busy", int'(busy), 1, 1);
    wait_done(50, 1'b0, lat, seq, nseq);
    chk("cont_latency1", lat, LAT, LAT);
    chk("cont_no_gap1", int'(busy), 1, 1);
    wait_done(-1, 1'b0, lat, seq, nseq);
    chk("cont_latency2", lat, LAT, LAT);
    chk("cont_no_gap2", int'(busy), 1, 1);
    wait_done(-1, 1'b1, lat, seq, nseq);
    chk("cont_latency3", lat, LAT, LAT);
    chk("cont_stop_idle", int'(busy), 0, 0);
    cnt_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) cnt_busy++;
    end
    chk("start_not_queued", cnt_busy, 0, 0);
    chk("sb_drained", sb.size(), 0, 0);

    // Reset during the green gate window, then a fresh sweep
    sb.push_back('{10, 10, 10, 10});
    pulse_start();
    lat = 0;
    while (filter_sel != 2'b11 && lat < 1000) begin @(negedge clk); lat++; end
    repeat (30) @(negedge clk);
    chk("red_stored_before_reset", int'(cnt_red), 9, 11);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cnt_red", int'(cnt_red), 0, 0);
    chk("midrst_busy", int'(busy), 0, 0);
    chk("midrst_filter_sel", int'(filter_sel), 0, 0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    per = '{5, 10, 20, 50};
    sb.push_back('{20, 10, 5, 2});
    pulse_start();
    wait_done(-1, 1'b0, lat, seq, nseq);
    chk("post_reset_latency", lat, LAT, LAT);
    chk("post_reset_seq", int'(seq), 'h36, 'h36);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
